// File: rtl/uart_rx.sv
// 8N1 UART receiver for the PicoRV32 peripheral bus: two-flop line synchronizer,
// mid-bit sampling FSM, one-byte holding register with overrun/framing flags.
module uart_rx #(
    parameter int unsigned BAUD_DIVIDER = 64,
    parameter int unsigned HALF_BIT     = BAUD_DIVIDER / 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic        mem_instr,
    input  logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_wdata,
    input  logic [31:0] mem_addr,
    output logic [31:0] mem_rdata,
    input  logic        serialIn
);

    localparam int unsigned TIMER_W = $clog2(BAUD_DIVIDER + 2);
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned BUS_W   = 32;

    localparam logic [TIMER_W-1:0] TIMER_BIT  = TIMER_W'(BAUD_DIVIDER);
    localparam logic [TIMER_W-1:0] TIMER_HALF = TIMER_W'(HALF_BIT);
    localparam logic [CNT_W-1:0]   LAST_BIT   = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_e;

    state_e              state_q, state_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]   shifter_q, shifter_d;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                overrun_q, overrun_d;
    logic                framing_err_q, framing_err_d;
    logic                mem_ready_q, mem_ready_d;
    logic [BUS_W-1:0]    mem_rdata_q, mem_rdata_d;
    logic [1:0]          sync_q;

    logic rx_s;
    logic deliver;
    logic frame_err;
    logic bus_accept;
    logic bus_write;
    logic sel_status;
    logic data_read_acc;
    logic status_wr;
    logic unused_bus;

    // Only address bit 2 and wdata bits 1..2 carry meaning.
    assign unused_bus = ^{mem_instr, mem_addr[31:3], mem_addr[1:0],
                          mem_wdata[31:3], mem_wdata[0]};

    assign rx_s      = sync_q[1];
    assign mem_ready = mem_ready_q;
    assign mem_rdata = mem_rdata_q;

    // State and register storage; the synchronizer idles high like the line.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q        <= 2'b11;
            state_q       <= S_IDLE;
            timer_q       <= '0;
            bit_cnt_q     <= '0;
            shifter_q     <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            overrun_q     <= 1'b0;
            framing_err_q <= 1'b0;
            mem_ready_q   <= 1'b0;
            mem_rdata_q   <= '0;
        end else begin
            sync_q        <= {sync_q[0], serialIn};
            state_q       <= state_d;
            timer_q       <= timer_d;
            bit_cnt_q     <= bit_cnt_d;
            shifter_q     <= shifter_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            overrun_q     <= overrun_d;
            framing_err_q <= framing_err_d;
            mem_ready_q   <= mem_ready_d;
            mem_rdata_q   <= mem_rdata_d;
        end
    end

    // Receive FSM: timer restarts on every state entry and samples land mid-bit.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q + TIMER_W'(1);
        bit_cnt_d = bit_cnt_q;
        shifter_d = shifter_q;
        deliver   = 1'b0;
        frame_err = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d = S_START;
                    timer_d = '0;
                end
            end
            S_START: begin
                if (timer_q == TIMER_HALF) begin
                    timer_d = '0;
                    if (!rx_s) begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (timer_q == TIMER_BIT) begin
                    shifter_d = {rx_s, shifter_q[DATA_W-1:1]};
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    timer_d   = '0;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (timer_q == TIMER_BIT) begin
                    timer_d = '0;
                    if (rx_s) begin
                        deliver = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        frame_err = 1'b1;
                        state_d   = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // A held-low line is one error, not a stream of false frames.
                if (rx_s) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase
    end

    // Bus decode, holding register and flags; a set beats a clear in the same cycle.
    always_comb begin
        bus_accept    = mem_valid & enable & ~mem_ready_q;
        bus_write     = |mem_wstrb;
        sel_status    = mem_addr[2];
        data_read_acc = bus_accept & ~bus_write & ~sel_status;
        status_wr     = bus_accept & bus_write & sel_status & mem_wstrb[0];

        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q;
        overrun_d     = overrun_q;
        framing_err_d = framing_err_q;
        mem_ready_d   = bus_accept;
        mem_rdata_d   = '0;

        if (data_read_acc) begin
            rx_valid_d = 1'b0;
        end
        if (status_wr && mem_wdata[1]) begin
            overrun_d = 1'b0;
        end
        if (status_wr && mem_wdata[2]) begin
            framing_err_d = 1'b0;
        end

        // A byte landing on the cycle its predecessor is read is not an overrun.
        if (deliver) begin
            if (!rx_valid_q || data_read_acc) begin
                rx_data_d  = shifter_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
        if (frame_err) begin
            framing_err_d = 1'b1;
        end

        if (bus_accept && !bus_write) begin
            if (sel_status) begin
                mem_rdata_d = {29'b0, framing_err_q, overrun_q, rx_valid_q};
            end else begin
                mem_rdata_d = {24'b0, rx_data_q};
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames driven bit by bit on serialIn, registers
// read back over the bus and compared with hand-computed values.
module tb_uart_rx;

    localparam int BIT_CYC   = 65;
    localparam int FRAME_CYC = 10 * BIT_CYC;
    localparam logic [31:0] A_DATA   = 32'h0;
    localparam logic [31:0] A_STATUS = 32'h4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        enable = 1'b0;
    logic        mem_valid = 1'b0;
    logic        mem_ready;
    logic        mem_instr = 1'b0;
    logic [3:0]  mem_wstrb = 4'h0;
    logic [31:0] mem_wdata = 32'h0;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] mem_rdata;
    logic        serialIn = 1'b1;

    int passed = 0;
    int total  = 0;

    uart_rx #(.BAUD_DIVIDER(64)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .enable    (enable),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_instr (mem_instr),
        .mem_wstrb (mem_wstrb),
        .mem_wdata (mem_wdata),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .serialIn  (serialIn)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One bus request held for a single cycle; ready sampled before, after and two cycles on.
    task automatic bus(input logic en, input logic [31:0] addr, input logic [3:0] wstrb,
                       input logic [31:0] wdata, output logic [31:0] rd,
                       output logic [2:0] rdy, output logic [31:0] rd_after);
        @(negedge clk);
        rdy[0]    = mem_ready;
        enable    = en;
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wstrb = wstrb;
        mem_wdata = wdata;
        @(negedge clk);
        rdy[1]    = mem_ready;
        rd        = mem_rdata;
        mem_valid = 1'b0;
        enable    = 1'b0;
        mem_wstrb = 4'h0;
        mem_wdata = 32'h0;
        @(negedge clk);
        rdy[2]    = mem_ready;
        rd_after  = mem_rdata;
    endtask

    task automatic rd_reg(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] rd, rd_after;
        logic [2:0]  rdy;
        bus(1'b1, addr, 4'h0, 32'h0, rd, rdy, rd_after);
        chk(tag, rd, exp);
    endtask

    // Full 8N1 frame; optional DATA read request and reset pulse at given cycle offsets.
    task automatic send_frame(input logic [7:0] b, input logic stop_v, input int read_at,
                              input int rst_at, output logic [31:0] rd, output logic rdy);
        int idx;
        rd  = 32'h0;
        rdy = 1'b0;
        for (int c = 0; c < FRAME_CYC; c++) begin
            @(negedge clk);
            idx = c / BIT_CYC;
            if (idx == 0)      serialIn = 1'b0;
            else if (idx == 9) serialIn = stop_v;
            else               serialIn = b[idx-1];
            if (read_at >= 0 && c == read_at) begin
                enable    = 1'b1;
                mem_valid = 1'b1;
                mem_addr  = A_DATA;
                mem_wstrb = 4'h0;
            end
            if (read_at >= 0 && c == read_at + 1) begin
                rd        = mem_rdata;
                rdy       = mem_ready;
                mem_valid = 1'b0;
                enable    = 1'b0;
            end
            if (rst_at >= 0 && c == rst_at)     resetn = 1'b0;
            if (rst_at >= 0 && c == rst_at + 3) resetn = 1'b1;
        end
    endtask

    initial begin
        logic [31:0] rd, rd_after;
        logic [2:0]  rdy;
        logic        rdy1;

        // Reset
        idle(3);
        chk("reset_ready", 32'(mem_ready), 32'h0);
        chk("reset_rdata", mem_rdata, 32'h0);
        resetn = 1'b1;
        idle(5);
        rd_reg("reset_status", A_STATUS, 32'h0);

        // Single frame 0x55
        send_frame(8'h55, 1'b1, -1, -1, rd, rdy1);
        idle(5);
        rd_reg("t1_status", A_STATUS, 32'h1);
        bus(1'b1, A_DATA, 4'h0, 32'h0, rd, rdy, rd_after);
        chk("t1_data", rd, 32'h55);
        chk("t1_ready_pulse", 32'(rdy), 32'h2);
        chk("t1_rdata_idle", rd_after, 32'h0);
        rd_reg("t1_status_after", A_STATUS, 32'h0);

        // Overrun: 0xA3 then 0x5C without reading
        send_frame(8'hA3, 1'b1, -1, -1, rd, rdy1);
        send_frame(8'h5C, 1'b1, -1, -1, rd, rdy1);
        idle(5);
        rd_reg("t2_status", A_STATUS, 32'h3);
        rd_reg("t2_data", A_DATA, 32'hA3);
        bus(1'b1, A_STATUS, 4'h1, 32'h2, rd, rdy, rd_after);
        chk("t2_wr_ack", 32'(rdy), 32'h2);
        rd_reg("t2_status_clr", A_STATUS, 32'h0);

        // 20-cycle low glitch
        @(negedge clk);
        serialIn = 1'b0;
        idle(20);
        serialIn = 1'b1;
        idle(150);
        rd_reg("t3_status", A_STATUS, 32'h0);

        // Framing error with line held low, then a good frame
        send_frame(8'h81, 1'b0, -1, -1, rd, rdy1);
        idle(20);
        rd_reg("t4_status_ferr", A_STATUS, 32'h4);
        idle(107);
        serialIn = 1'b1;
        idle(700);
        rd_reg("t4_status_one_err", A_STATUS, 32'h4);
        send_frame(8'h42, 1'b1, -1, -1, rd, rdy1);
        idle(5);
        rd_reg("t4_status_byte", A_STATUS, 32'h5);
        rd_reg("t4_data", A_DATA, 32'h42);
        bus(1'b1, A_STATUS, 4'h1, 32'h4, rd, rdy, rd_after);
        rd_reg("t4_status_clr", A_STATUS, 32'h0);

        // DATA read accepted on the delivery cycle of the second byte
        send_frame(8'h11, 1'b1, -1, -1, rd, rdy1);
        send_frame(8'h22, 1'b1, 620, -1, rd, rdy1);
        chk("t5_read_old", rd, 32'h11);
        chk("t5_read_ready", 32'(rdy1), 32'h1);
        idle(5);
        rd_reg("t5_status", A_STATUS, 32'h1);
        rd_reg("t5_data_new", A_DATA, 32'h22);
        rd_reg("t5_status_after", A_STATUS, 32'h0);

        // Reset mid-frame (data bit 4), then a clean frame
        send_frame(8'h33, 1'b1, -1, -1, rd, rdy1);
        send_frame(8'h44, 1'b1, -1, -1, rd, rdy1);
        idle(5);
        rd_reg("t6_status_pre", A_STATUS, 32'h3);
        send_frame(8'hFF, 1'b1, -1, 350, rd, rdy1);
        chk("t6_ready_post_rst", 32'(mem_ready), 32'h0);
        chk("t6_rdata_post_rst", mem_rdata, 32'h0);
        idle(10);
        rd_reg("t6_status_rst", A_STATUS, 32'h0);
        send_frame(8'h7E, 1'b1, -1, -1, rd, rdy1);
        idle(5);
        rd_reg("t6_status", A_STATUS, 32'h1);
        bus(1'b0, A_DATA, 4'h0, 32'h0, rd, rdy, rd_after);
        chk("t6_no_enable", 32'(rdy), 32'h0);
        bus(1'b1, A_DATA, 4'hF, 32'h99, rd, rdy, rd_after);
        chk("t6_wr_data_ack", 32'(rdy), 32'h2);
        rd_reg("t6_status_kept", A_STATUS, 32'h1);
        rd_reg("t6_data", A_DATA, 32'h7E);
        rd_reg("t6_status_after", A_STATUS, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
